// File: rtl/register_file8.sv
// Eight-entry register bank with decoded writes, registered reads and a one-entry-per-cycle clear sweep.
// Optional REGFILE_BYPASS_EN: forward same-edge writes and sweep zeroing onto rd_data.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr_req starts a sweep
// CLEAR | sweep zeroing entry[cnt] each cycle, writes dropped, busy=1
module register_file8 #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic [2:0]           rd_addr,
    output logic [BUS_WIDTH-1:0] rd_data,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]           state;
    logic [2:0]           cnt;
    logic [BUS_WIDTH-1:0] mem [8];
    logic                 wr_ok;
    logic [BUS_WIDTH-1:0] rd_next;

    assign wr_ok = wr_en && (state == IDLE);

    always_comb begin
        rd_next = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr))
            rd_next = wr_data;
        if ((state == CLEAR) && (cnt == rd_addr))
            rd_next = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            clr_done <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < 8; i++)
                mem[i] <= '0;
        end else begin
            rd_data  <= rd_next;
            clr_done <= 1'b0;
            if (state == IDLE) begin
                if (wr_ok)
                    mem[wr_addr] <= wr_data;
                if (clr_req) begin
                    state <= CLEAR;
                    cnt   <= 3'd0;
                end
            end else begin
                mem[cnt] <= '0;
                cnt      <= cnt + 3'd1;    // wraps to 0 on the last entry
                if (cnt == 3'd7) begin
                    state    <= IDLE;
                    clr_done <= 1'b1;
                end
            end
        end
    end

    // busy decodes the state flop directly, so it is still a registered output
    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_register_file8.sv
// Self-checking bench for register_file8: array-based reference model plus directed literal checks.
module tb_register_file8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    int passed = 0;
    int total  = 0;

    register_file8 #(.BUS_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .busy(busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Reference model: bank as an array, sweep tracked as "entries still to clear".
    logic [15:0] m_mem [8];
    logic [15:0] m_rd;
    logic        m_busy;
    logic        m_done;
    logic [3:0]  m_left;
    logic [15:0] m_nrd;
    logic [2:0]  m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
            m_rd = 16'h0; m_busy = 1'b0; m_done = 1'b0; m_left = 4'd0;
        end else begin
            m_nrd = m_mem[rd_addr];
            if (m_left != 4'd0) begin
                m_idx = 3'(4'd8 - m_left);
`ifdef REGFILE_BYPASS_EN
                if (m_idx == rd_addr) m_nrd = 16'h0;
`endif
                m_mem[m_idx] = 16'h0;
                m_left = m_left - 4'd1;
                m_done = (m_left == 4'd0);
            end else begin
                m_done = 1'b0;
                if (wr_en) begin
`ifdef REGFILE_BYPASS_EN
                    if (wr_addr == rd_addr) m_nrd = wr_data;
`endif
                    m_mem[wr_addr] = wr_data;
                end
                if (clr_req) m_left = 4'd8;
            end
            m_rd   = m_nrd;
            m_busy = (m_left != 4'd0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_rd_data", {16'h0, rd_data}, {16'h0, m_rd});
        check("model_busy", {31'h0, busy}, {31'h0, m_busy});
        check("model_clr_done", {31'h0, clr_done}, {31'h0, m_done});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            check(name, {16'h0, rd_data}, 32'h0);
        end
    endtask

    int cyc;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
        rd_addr = 3'd0; clr_req = 1'b0;
        tick(); tick();
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_clr_done", {31'h0, clr_done}, 32'h0);
        rst = 1'b0;

        // 1: reads after reset
        read_all_zero("post_reset_read");

        // 2: write 0x1000+i then read back
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            check("readback", {16'h0, rd_data}, 32'h1000 + 32'(i));
        end

        // 3: same-edge write/read of entry 3
        rd_addr = 3'd3;
        wr(3'd3, 16'hBEEF);
`ifdef REGFILE_BYPASS_EN
        check("wr_rd_same_edge", {16'h0, rd_data}, 32'hBEEF);
`else
        check("wr_rd_same_edge", {16'h0, rd_data}, 32'h1003);
`endif
        tick();
        check("wr_rd_next_edge", {16'h0, rd_data}, 32'hBEEF);

        // 4: clear sweep with a dropped mid-sweep write
        rd_addr = 3'd5;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("sweep_busy_c1", {31'h0, busy}, 32'h1);
        for (int k = 2; k <= 8; k++) begin
            if (k == 4) begin
                wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00AA; clr_req = 1'b1;
            end
            tick();
            wr_en = 1'b0; clr_req = 1'b0;
            check("sweep_busy", {31'h0, busy}, 32'h1);
            check("sweep_no_done", {31'h0, clr_done}, 32'h0);
        end
        tick();
        check("sweep_end_busy", {31'h0, busy}, 32'h0);
        check("sweep_end_done", {31'h0, clr_done}, 32'h1);
        tick();
        check("done_one_cycle", {31'h0, clr_done}, 32'h0);
        check("no_queued_sweep", {31'h0, busy}, 32'h0);
        read_all_zero("post_sweep_read");

        // 5: write and clr_req on the same edge
        wr(3'd6, 16'h5555);
        rd_addr = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        check("simul_busy", {31'h0, busy}, 32'h1);
        cyc = 0;
        while (!clr_done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("simul_done_seen", {31'h0, clr_done}, 32'h1);
        check("simul_sweep_len", 32'(cyc), 32'd8);
        tick();
        check("simul_entry2_zero", {16'h0, rd_data}, 32'h0);

        // 6: async reset in the middle of a sweep
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h00A0 + 16'(i));
        rd_addr = 3'd7;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        check("pre_reset_rd", {16'h0, rd_data}, 32'h00A7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        check("async_rst_done", {31'h0, clr_done}, 32'h0);
        check("async_rst_rd", {16'h0, rd_data}, 32'h0);
        tick();
        rst = 1'b0;
        read_all_zero("post_abort_read");
        check("abort_idle", {31'h0, busy}, 32'h0);
        wr(3'd4, 16'hC0DE);
        rd_addr = 3'd4;
        tick();
        check("abort_write_ok", {16'h0, rd_data}, 32'hC0DE);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
